// File: rtl/sdram_op_scheduler.sv
// SDRAM operation scheduler: power-up init, refresh-debt tracking and Z3/aux
// arbitration, issuing one operation at a time over a start/done handshake.
module sdram_op_scheduler #(
  parameter int unsigned INIT_DELAY       = 5000,
  parameter int unsigned INIT_REFRESHES   = 8,
  parameter int unsigned REFRESH_INTERVAL = 195,
  parameter int unsigned URGENT_DEBT      = 4,
  parameter int unsigned OP_TIMEOUT       = 64
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       z3_req,
  input  logic       aux_req,
  input  logic       op_done,
  output logic       op_start,
  output logic [2:0] op_sel,
  output logic       z3_gnt,
  output logic       aux_gnt,
  output logic       init_done,
  output logic [2:0] refresh_debt,
  output logic       refresh_overflow,
  output logic       op_error
);

  localparam int unsigned DLY_W  = $clog2(INIT_DELAY + 1);
  localparam int unsigned REF_W  = $clog2(INIT_REFRESHES + 1);
  localparam int unsigned INT_W  = $clog2(REFRESH_INTERVAL + 1);
  localparam int unsigned TMO_W  = $clog2(OP_TIMEOUT + 1);
  localparam int unsigned DEBT_W = 3;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PRE  = 3'd1;
  localparam logic [2:0] OP_REF  = 3'd2;
  localparam logic [2:0] OP_MODE = 3'd3;
  localparam logic [2:0] OP_Z3   = 3'd4;
  localparam logic [2:0] OP_AUX  = 3'd5;

  typedef enum logic [2:0] {
    ST_WAIT, ST_INIT_PRE, ST_INIT_REF, ST_INIT_MODE, ST_IDLE, ST_BUSY, ST_RECOVER
  } state_t;

  state_t            state, state_d;
  logic [DLY_W-1:0]  dly_cnt, dly_cnt_d;
  logic [REF_W-1:0]  ref_cnt, ref_cnt_d;
  logic [INT_W-1:0]  int_cnt, int_cnt_d;
  logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_d;
  logic [DEBT_W-1:0] debt_d;
  logic              rr_aux, rr_aux_d;
  logic              op_start_d, z3_gnt_d, aux_gnt_d, init_done_d;
  logic              overflow_d, op_error_d;
  logic [2:0]        op_sel_d;
  logic              debt_inc, debt_dec, done_ok, op_active, timeout, finish, grant_aux;

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state            <= ST_WAIT;
      dly_cnt          <= '0;
      ref_cnt          <= '0;
      int_cnt          <= '0;
      tmo_cnt          <= '0;
      rr_aux           <= 1'b0;
      op_start         <= 1'b0;
      op_sel           <= OP_NOP;
      z3_gnt           <= 1'b0;
      aux_gnt          <= 1'b0;
      init_done        <= 1'b0;
      refresh_debt     <= '0;
      refresh_overflow <= 1'b0;
      op_error         <= 1'b0;
    end else begin
      state            <= state_d;
      dly_cnt          <= dly_cnt_d;
      ref_cnt          <= ref_cnt_d;
      int_cnt          <= int_cnt_d;
      tmo_cnt          <= tmo_cnt_d;
      rr_aux           <= rr_aux_d;
      op_start         <= op_start_d;
      op_sel           <= op_sel_d;
      z3_gnt           <= z3_gnt_d;
      aux_gnt          <= aux_gnt_d;
      init_done        <= init_done_d;
      refresh_debt     <= debt_d;
      refresh_overflow <= overflow_d;
      op_error         <= op_error_d;
    end
  end

  // Next-state, op issue, refresh debt and timeout
  always_comb begin
    state_d     = state;
    dly_cnt_d   = dly_cnt;
    ref_cnt_d   = ref_cnt;
    int_cnt_d   = int_cnt;
    tmo_cnt_d   = tmo_cnt;
    rr_aux_d    = rr_aux;
    op_start_d  = 1'b0;
    op_sel_d    = op_sel;
    z3_gnt_d    = z3_gnt;
    aux_gnt_d   = aux_gnt;
    init_done_d = init_done;
    debt_d      = refresh_debt;
    overflow_d  = refresh_overflow;
    op_error_d  = op_error;
    debt_inc    = 1'b0;
    debt_dec    = 1'b0;
    grant_aux   = 1'b0;

    // op_done in the op_start cycle belongs to no op and is ignored
    done_ok   = op_done && !op_start;
    op_active = (state == ST_INIT_PRE) || (state == ST_INIT_REF) ||
                (state == ST_INIT_MODE) || (state == ST_BUSY);
    timeout   = op_active && !done_ok && (tmo_cnt == TMO_W'(OP_TIMEOUT - 1));
    finish    = done_ok || timeout;

    if (op_active) tmo_cnt_d = tmo_cnt + TMO_W'(1);
    if (timeout)   op_error_d = 1'b1;

    case (state)
      ST_WAIT: begin
        if (dly_cnt == DLY_W'(INIT_DELAY - 1)) begin
          state_d    = ST_INIT_PRE;
          op_start_d = 1'b1;
          op_sel_d   = OP_PRE;
          tmo_cnt_d  = '0;
        end else begin
          dly_cnt_d = dly_cnt + DLY_W'(1);
        end
      end
      ST_INIT_PRE: begin
        if (finish) begin
          state_d    = ST_INIT_REF;
          op_start_d = 1'b1;
          op_sel_d   = OP_REF;
          tmo_cnt_d  = '0;
          ref_cnt_d  = REF_W'(1);
        end
      end
      ST_INIT_REF: begin
        if (finish) begin
          op_start_d = 1'b1;
          tmo_cnt_d  = '0;
          if (ref_cnt == REF_W'(INIT_REFRESHES)) begin
            state_d  = ST_INIT_MODE;
            op_sel_d = OP_MODE;
          end else begin
            op_sel_d  = OP_REF;
            ref_cnt_d = ref_cnt + REF_W'(1);
          end
        end
      end
      ST_INIT_MODE: begin
        if (finish) begin
          state_d     = ST_IDLE;
          op_sel_d    = OP_NOP;
          init_done_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if ((refresh_debt >= DEBT_W'(URGENT_DEBT)) ||
            (!z3_req && !aux_req && (refresh_debt != '0))) begin
          state_d    = ST_BUSY;
          op_start_d = 1'b1;
          op_sel_d   = OP_REF;
          tmo_cnt_d  = '0;
          debt_dec   = 1'b1;
        end else if (z3_req || aux_req) begin
          grant_aux  = aux_req && (!z3_req || rr_aux);
          state_d    = ST_BUSY;
          op_start_d = 1'b1;
          op_sel_d   = grant_aux ? OP_AUX : OP_Z3;
          tmo_cnt_d  = '0;
          z3_gnt_d   = !grant_aux;
          aux_gnt_d  = grant_aux;
          rr_aux_d   = !grant_aux;
        end
      end
      ST_BUSY: begin
        if (finish) begin
          state_d   = ST_RECOVER;
          op_sel_d  = OP_NOP;
          z3_gnt_d  = 1'b0;
          aux_gnt_d = 1'b0;
        end
      end
      ST_RECOVER: state_d = ST_IDLE;
      default:    state_d = ST_WAIT;
    endcase

    if (init_done) begin
      if (int_cnt == INT_W'(REFRESH_INTERVAL - 1)) begin
        int_cnt_d = '0;
        debt_inc  = 1'b1;
      end else begin
        int_cnt_d = int_cnt + INT_W'(1);
      end
    end

    // Simultaneous owe and pay cancel out; owing at full scale saturates
    if (debt_inc && !debt_dec) begin
      if (refresh_debt == DEBT_W'(7)) overflow_d = 1'b1;
      else                            debt_d = refresh_debt + DEBT_W'(1);
    end else if (debt_dec && !debt_inc) begin
      debt_d = refresh_debt - DEBT_W'(1);
    end
  end

endmodule

// File: doc/sdram_op_scheduler.md
Name: sdram_op_scheduler

Overview:
Sequences and shares the card's SDRAM between the Zorro III slave path, a secondary auxiliary requester (memory-clear/test engine) and periodic auto-refresh. Runs the power-up init sequence, tracks refresh debt, arbitrates accesses and issues one operation at a time to the SDRAM command datapath via a start/done handshake. Sits between the Z3 cycle state machine and the SDRAM command generator.

Parameters:
INIT_DELAY, 5000, CLK cycles of idle wait after reset before init (≥200 µs at 25 MHz)
INIT_REFRESHES, 8, auto-refresh operations issued during init
REFRESH_INTERVAL, 195, CLK cycles per refresh-debt increment (7.8 µs at 25 MHz)
URGENT_DEBT, 4, debt level at which refresh outranks all requesters (1..7)
OP_TIMEOUT, 64, CLK cycles in BUSY without op_done before abort

Ports:
CLK  in  1  bus clock; all logic on rising edge
RESET  in  1  synchronous, active-high reset
z3_req  in  1  Z3 access request; level, held until op_done seen
aux_req  in  1  auxiliary access request; same rules as z3_req
op_done  in  1  one-cycle pulse from datapath: current op complete
op_start  out  1  one-cycle pulse: datapath begins op_sel
op_sel  out  3  0 NOP, 1 PRECHARGE_ALL, 2 REFRESH, 3 LOAD_MODE, 4 ACCESS_Z3, 5 ACCESS_AUX
z3_gnt  out  1  high while Z3 access owns SDRAM
aux_gnt  out  1  high while aux access owns SDRAM
init_done  out  1  high once init sequence complete
refresh_debt  out  3  outstanding refreshes owed
refresh_overflow  out  1  sticky: debt increment attempted at 7
op_error  out  1  sticky: OP_TIMEOUT abort occurred

Behaviour:
- Reset values (on any cycle RESET=1, including mid-operation): FSM=WAIT, all outputs 0, op_sel=0, delay/refresh/timeout counters 0, round-robin pointer=Z3, sticky flags cleared. After RESET falls, full init repeats.
- States: WAIT, INIT_PRE, INIT_REF, INIT_MODE, IDLE, BUSY, RECOVER.
- WAIT: count INIT_DELAY cycles, then INIT_PRE.
- Issuing an op (any state): on the transition edge op_start=1 and op_sel set for exactly the first BUSY-phase cycle; op_sel held until op_done; op_done accepted only after the op_start cycle (ignored in same cycle).
- INIT_PRE: issue PRECHARGE_ALL; on op_done -> INIT_REF. INIT_REF: issue REFRESH INIT_REFRESHES times back-to-back, each after previous op_done -> INIT_MODE. INIT_MODE: issue LOAD_MODE; on op_done init_done=1 (registered, next cycle) -> IDLE.
- Requests ignored (no grant) before init_done.
- IDLE arbitration, priority order evaluated each cycle:
  1. refresh_debt ≥ URGENT_DEBT -> REFRESH
  2. z3_req and aux_req both high -> requester named by round-robin pointer
  3. single request -> that requester
  4. refresh_debt > 0 -> REFRESH
  5. else stay IDLE, op_sel=0
- Grant: z3_gnt/aux_gnt rises on the same edge as op_start; falls on edge after op_done. Pointer flips to the other requester after each access grant (refresh does not move it).
- Latency: request present in IDLE -> op_start next edge (1 cycle).
- BUSY -> RECOVER on op_done; RECOVER always -> IDLE after 1 cycle (requesters drop req on op_done; RECOVER prevents double service).
- Refresh debt: interval counter runs only when init_done=1, wraps at REFRESH_INTERVAL-1 and increments debt. Debt decrements on each REFRESH op_start in IDLE (init refreshes do not affect debt). Simultaneous increment and decrement -> unchanged. Increment at 7 -> stays 7, refresh_overflow=1.
- Timeout: counter cleared on op_start, counts in BUSY; reaching OP_TIMEOUT without op_done -> op_error=1, grants drop, op_sel=0, -> RECOVER. An aborted REFRESH is not re-credited. Timeout applies to init ops too (abort continues to next init step).
- Outputs registered; no combinational path from inputs to outputs.

Test Plan:
- Init: INIT_DELAY=10, INIT_REFRESHES=2, op_done 3 cycles after each op_start -> op_sel sequence 1,2,2,3, init_done rises cycle after 4th op_done; z3_req held high throughout gets no grant until after init_done.
- Single Z3 access: z3_req at IDLE cycle T -> op_start=1, op_sel=4, z3_gnt=1 at T+1; op_done at T+5 -> z3_gnt=0 at T+6, IDLE at T+7.
- Contention: z3_req and aux_req held high continuously (each dropped only on its own op_done, reasserted in RECOVER) -> grants alternate Z3, AUX, Z3, AUX.
- Urgent refresh: REFRESH_INTERVAL=8, URGENT_DEBT=2, op_done withheld 20 cycles on a Z3 access -> debt=2; next IDLE issues op_sel=2 despite aux_req; debt -> 1.
- Overflow/saturation: no op_done (OP_TIMEOUT large) for 80 cycles at interval 8 -> debt stays 7, refresh_overflow=1; increment and refresh issue on same cycle -> debt unchanged.
- Abort and reset: op_done never returned -> op_error=1 exactly OP_TIMEOUT cycles after op_start, gnt low; then RESET asserted mid-BUSY -> all outputs 0 next edge, op_error cleared, init sequence reruns.
